// File: rtl/alu_mul_sequencer.sv
// ALU issue/sequencing controller: single-cycle ADD/SUB/OR/AND plus an iterative
// radix-2 shift-add multiplier that stalls upstream stages until the product is ready.
// Optional build macro: MUL_EARLY_EXIT_EN ends the multiply once the remaining
// multiplier bits are all zero.
module alu_mul_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o
);

    // Shared ALU control encodings
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluMul = 3'b011;
    localparam logic [2:0] AluSub = 3'b110;

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [0:0] {StIdle, StMulRun} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                valid_q, valid_d;

    logic                accept;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   acc_step;
    logic [DATA_W-1:0]   mplier_shift;
    logic                last_iter;

    assign ready_o = (state_q == StIdle);
    assign accept  = valid_i && ready_o && !flush_i;
    assign stall_o = (state_q == StMulRun) ||
                     ((state_q == StIdle) && valid_i && (ALUCtrl_i == AluMul) && !flush_i);
    assign valid_o = valid_q;
    assign data_o  = res_q;
    assign zero_o  = valid_q && (res_q == '0);

    // Single-cycle ALU datapath; unknown codes fall through to ADD
    always_comb begin
        alu_res = data1_i + data2_i;
        case (ALUCtrl_i)
            AluSub:  alu_res = data1_i - data2_i;
            AluOr:   alu_res = data1_i | data2_i;
            AluAnd:  alu_res = data1_i & data2_i;
            default: alu_res = data1_i + data2_i;
        endcase
    end

    // One shift-add iteration and its termination condition
    always_comb begin
        acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        last_iter    = (cnt_q == CntW'(DATA_W - 1)) || (mplier_shift == '0);
`else
        last_iter    = (cnt_q == CntW'(DATA_W - 1));
`endif
    end

    // Next-state logic for the sequencer and multiplier registers
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        valid_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ALUCtrl_i == AluMul) begin
                        mcand_d  = data1_i;
                        mplier_d = data2_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMulRun;
                    end else begin
                        valid_d = 1'b1;
                        res_d   = alu_res;
                    end
                end
            end
            StMulRun: begin
                // A flush abandons the product without producing a result
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shift;
                    cnt_d    = cnt_q + CntW'(1);
                    if (last_iter) begin
                        state_d = StIdle;
                        valid_d = 1'b1;
                        res_d   = acc_step;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed table, corner-case sequences
// and randomized operations against an arithmetic reference model.
module tb_alu_mul_sequencer;

    localparam int unsigned W = 32;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          valid;
    logic [2:0]    ctrl;
    logic [W-1:0]  da;
    logic [W-1:0]  db;
    logic          ready_o;
    logic          stall_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          zero_o;

    int checks   = 0;
    int failures = 0;

    alu_mul_sequencer #(.DATA_W(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .flush_i   (flush),
        .valid_i   (valid),
        .ALUCtrl_i (ctrl),
        .data1_i   (da),
        .data2_i   (db),
        .ready_o   (ready_o),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .zero_o    (zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result: plain arithmetic truncated to W bits
    function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_MUL:  return a * b;
            default: return a + b;
        endcase
    endfunction

    // Cycles from the accept cycle to the valid_o cycle
    function automatic int model_latency(input logic [2:0] op, input logic [W-1:0] b);
        int n;
        if (op != OP_MUL) return 1;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return 1 + n;
`else
        n = W;
        return n + 1;
`endif
    endfunction

    // Issue one request, wait (bounded) for the result, check value, latency and pulse width
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int cyc;
        bit seen;
        @(negedge clk);
        check({name, "_ready"}, ready_o, 1'b1);
        valid = 1'b1; ctrl = op; da = a; db = b;
        #1;
        check({name, "_stall_req"}, stall_o, (op == OP_MUL));
        @(posedge clk);
        #1 valid = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (valid_o) seen = 1;
        end
        check({name, "_latency"}, cyc, lat);
        check({name, "_data"}, data_o, exp);
        check({name, "_zero"}, zero_o, (exp == '0));
        check({name, "_stall_done"}, stall_o, 1'b0);
        @(negedge clk);
        check({name, "_pulse"}, valid_o, 1'b0);
        check({name, "_hold"}, data_o, exp);
    endtask

    vec_t vecs[11];
    vec_t bb[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, stall_cnt, lat, k;
        bit seen, bad;
        logic [2:0] op;
        logic [W-1:0] a, b;

        vecs[0]  = '{OP_ADD, 32'd5,          32'd7,       32'd12};
        vecs[1]  = '{OP_SUB, 32'd3,          32'd3,       32'd0};
        vecs[2]  = '{OP_OR,  32'hF0,         32'h0F,      32'hFF};
        vecs[3]  = '{OP_AND, 32'hFF,         32'h0F,      32'h0F};
        vecs[4]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,       32'd0};
        vecs[5]  = '{OP_SUB, 32'd0,          32'd1,       32'hFFFF_FFFF};
        vecs[6]  = '{3'b111, 32'd5,          32'd6,       32'd11};
        vecs[7]  = '{OP_MUL, 32'd6,          32'd7,       32'd42};
        vecs[8]  = '{OP_MUL, 32'h0001_0000,  32'h0001_0000, 32'd0};
        vecs[9]  = '{OP_MUL, 32'd9,          32'd0,       32'd0};
        vecs[10] = '{OP_MUL, 32'd9,          32'd3,       32'd27};
        bb[0] = '{OP_SUB, 32'd3,   32'd3,   32'd0};
        bb[1] = '{OP_OR,  32'hF0,  32'h0F,  32'hFF};
        bb[2] = '{OP_AND, 32'hFF,  32'h0F,  32'h0F};

        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ctrl = OP_ADD; da = '0; db = '0;
        #12;
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, '0);
        check("rst_zero", zero_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", ready_o, 1'b1);
        check("rst_stall", stall_o, 1'b0);

        // Directed table
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   model_latency(vecs[i].op, vecs[i].b));

        // Back-to-back single-cycle ops
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check($sformatf("bb%0d_valid", i - 1), valid_o, 1'b1);
                check($sformatf("bb%0d_data", i - 1), data_o, bb[i-1].exp);
                check($sformatf("bb%0d_zero", i - 1), zero_o, (bb[i-1].exp == '0));
            end
            check($sformatf("bb%0d_ready", i), ready_o, 1'b1);
            if (i < 3) begin
                valid = 1'b1; ctrl = bb[i].op; da = bb[i].a; db = bb[i].b;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        check("bb_end_valid", valid_o, 1'b0);

        // MUL with an ADD held behind it
        lat = model_latency(OP_MUL, 32'd2);
        valid = 1'b1; ctrl = OP_MUL; da = 32'hFFFF_FFFF; db = 32'd2;
        #1;
        check("hold_stall_accept", stall_o, 1'b1);
        stall_cnt = 1;
        @(posedge clk);
        #1 ctrl = OP_ADD; da = 32'd1; db = 32'd2;
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (valid_o) seen = 1;
            else begin
                if (stall_o) stall_cnt++;
                check("hold_ready_busy", ready_o, 1'b0);
            end
        end
        check("hold_mul_latency", cyc, lat);
        check("hold_mul_data", data_o, 32'hFFFF_FFFE);
        check("hold_stall_cycles", stall_cnt, lat);
        check("hold_stall_drop", stall_o, 1'b0);
        check("hold_ready_done", ready_o, 1'b1);
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check("hold_add_valid", valid_o, 1'b1);
        check("hold_add_data", data_o, 32'd3);

        // Flush in the middle of a MUL
        lat = model_latency(OP_MUL, 32'd7);
        k = (lat > 12) ? 10 : 1;
        @(negedge clk);
        valid = 1'b1; ctrl = OP_MUL; da = 32'd6; db = 32'd7;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (k) @(negedge clk);
        check("flush_stall_running", stall_o, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_valid", valid_o, 1'b0);
        check("flush_ready", ready_o, 1'b1);
        check("flush_stall", stall_o, 1'b0);
        bad = 0;
        repeat (lat) begin
            @(negedge clk);
            if (valid_o) bad = 1;
        end
        check("flush_no_result", bad, 1'b0);
        run_op("flush_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

        // Flush wins over a request in IDLE
        @(negedge clk);
        valid = 1'b1; ctrl = OP_MUL; da = 32'd5; db = 32'd5; flush = 1'b1;
        #1;
        check("idle_flush_stall", stall_o, 1'b0);
        @(posedge clk);
        #1 valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_valid", valid_o, 1'b0);
        check("idle_flush_ready", ready_o, 1'b1);
        check("idle_flush_data_held", data_o, 32'd2);

        // Reset in the middle of a MUL
        lat = model_latency(OP_MUL, 32'd4);
        k = (lat > 12) ? 5 : 1;
        @(negedge clk);
        valid = 1'b1; ctrl = OP_MUL; da = 32'd3; db = 32'd4;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (k) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_data", data_o, '0);
        check("midrst_zero", zero_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", ready_o, 1'b1);
        run_op("midrst_mul", OP_MUL, 32'd3, 32'd4, 32'd12, lat);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_OR;
                3: op = OP_AND;
                4: op = OP_MUL;
                default: op = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b111;
            endcase
            a = $urandom;
            b = $urandom;
            if (op == OP_MUL && $urandom_range(0, 1) == 0) b = $urandom_range(0, 255);
            if (op == OP_SUB && $urandom_range(0, 3) == 0) b = a;
            run_op($sformatf("rnd%0d", i), op, a, b, model_result(op, a, b),
                   model_latency(op, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
